// File: rtl/mod_add_pkg.sv
// Shared widths and types for the modular adder.
// The default widths fit a 23-bit modulus with 24-bit addends.
package mod_add_pkg;

    localparam int A_W_DEF = 24;
    localparam int Q_W_DEF = 23;

    typedef logic [A_W_DEF-1:0] operand_t;
    typedef logic [A_W_DEF:0]   sum_t;
    typedef logic [Q_W_DEF-1:0] mod_t;

endpackage

// File: rtl/mod_add.sv
// Single-cycle modular adder: one conditional subtraction, then one register stage.
// Operands above q are accepted as-is; the result is only partially reduced in that case.
module mod_add
    import mod_add_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int Q_W = Q_W_DEF
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           valid_i,
    input  logic [A_W-1:0] a_i,
    input  logic [A_W-1:0] b_i,
    input  logic [Q_W-1:0] q_i,
    output logic [Q_W-1:0] c_o,
    output logic           valid_o
);

    localparam int S_W = A_W + 1;

    logic [S_W-1:0] sum;
    logic [S_W-1:0] q_ext;
    logic [Q_W-1:0] c_next;

    // Compare against the full carry-out sum so large operands are never misclassified.
    always_comb begin
        sum    = {1'b0, a_i} + {1'b0, b_i};
        q_ext  = S_W'(q_i);
        c_next = Q_W'((sum < q_ext) ? sum : (sum - q_ext));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c_o     <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                c_o <= c_next;
            end
        end
    end

endmodule

// File: tb/tb_mod_add.sv
// Scoreboard bench for mod_add: stimulus pushes expected results, a negedge monitor checks them.
// Directed vectors carry hand-computed results; random vectors use a small reference model.
module tb_mod_add;

    localparam int A_W = 24;
    localparam int Q_W = 23;

    logic           clk_i;
    logic           rst_ni;
    logic           valid_i;
    logic [A_W-1:0] a_i;
    logic [A_W-1:0] b_i;
    logic [Q_W-1:0] q_i;
    logic [Q_W-1:0] c_o;
    logic           valid_o;

    logic [Q_W-1:0] exp_c;
    logic [Q_W-1:0] sb[$];
    logic [Q_W-1:0] last_c;
    int             checks;
    int             failures;

    mod_add #(.A_W(A_W), .Q_W(Q_W)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .q_i     (q_i),
        .c_o     (c_o),
        .valid_o (valid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [Q_W-1:0] refModAdd(input logic [A_W-1:0] a,
                                                 input logic [A_W-1:0] b,
                                                 input logic [Q_W-1:0] q);
        logic [A_W:0] s;
        logic [A_W:0] qe;
        logic [A_W:0] r;
        s  = {1'b0, a} + {1'b0, b};
        qe = {{(A_W + 1 - Q_W){1'b0}}, q};
        if (s < qe) r = s;
        else        r = s - qe;
        return r[Q_W-1:0];
    endfunction

    // A result is owed one cycle after every valid_i sampled out of reset.
    always @(posedge clk_i) begin
        if (rst_ni && valid_i) sb.push_back(exp_c);
    end

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            checkOutput("reset_c_o", 32'(c_o), 32'd0);
            checkOutput("reset_valid_o", 32'(valid_o), 32'd0);
            last_c = '0;
        end else if (sb.size() > 0) begin
            logic [Q_W-1:0] e;
            e = sb.pop_front();
            checkOutput("valid_o_expected", 32'(valid_o), 32'd1);
            checkOutput("c_o", 32'(c_o), 32'(e));
            last_c = e;
        end else begin
            checkOutput("valid_o_idle", 32'(valid_o), 32'd0);
            checkOutput("c_o_hold", 32'(c_o), 32'(last_c));
        end
    end

    task automatic applyStimulus(input logic [A_W-1:0] a, input logic [A_W-1:0] b,
                                 input logic [Q_W-1:0] q, input logic [Q_W-1:0] e);
        @(negedge clk_i);
        valid_i = 1'b1;
        a_i     = a;
        b_i     = b;
        q_i     = q;
        exp_c   = e;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            valid_i = 1'b0;
            a_i     = A_W'($urandom);
            b_i     = A_W'($urandom);
            q_i     = Q_W'($urandom);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        last_c   = '0;
        rst_ni   = 1'b0;
        valid_i  = 1'b0;
        a_i      = '0;
        b_i      = '0;
        q_i      = '0;
        exp_c    = '0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle(2);

        // Directed vectors, issued back-to-back.
        applyStimulus(24'd5, 24'd3, 23'd10, 23'd8);
        applyStimulus(24'd7, 24'd3, 23'd10, 23'd0);
        applyStimulus(24'd10, 24'd10, 23'd10, 23'd10);
        applyStimulus(24'h7FFFFF, 24'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF);
        applyStimulus(24'hFFFFFF, 24'hFFFFFF, 23'd1, 23'h7FFFFD);
        applyStimulus(24'd3, 24'd4, 23'd0, 23'd7);
        applyStimulus(24'd0, 24'd0, 23'd0, 23'd0);
        applyStimulus(24'hFFFFFF, 24'd1, 23'd0, 23'd0);
        idle(3);

        // Reset arrives while a result is in flight; it must vanish.
        applyStimulus(24'd5, 24'd3, 23'd10, 23'd8);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        rst_ni  = 1'b0;
        sb.delete();
        #1;
        checkOutput("async_reset_c_o", 32'(c_o), 32'd0);
        checkOutput("async_reset_valid_o", 32'(valid_o), 32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle(4);

        // First transaction after reset release.
        applyStimulus(24'd3, 24'd4, 23'd0, 23'd7);
        idle(2);

        // Random vectors with a, b in [0, q], sometimes with idle gaps.
        for (int i = 0; i < 300; i++) begin
            logic [Q_W-1:0] q;
            logic [A_W-1:0] a;
            logic [A_W-1:0] b;
            q = Q_W'($urandom_range(1, (1 << Q_W) - 1));
            a = A_W'($urandom_range(0, int'(q)));
            b = A_W'($urandom_range(0, int'(q)));
            applyStimulus(a, b, q, refModAdd(a, b, q));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(4);

        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
